// File: rtl/cop0_pkg.sv
// cop0_pkg: shared definitions for the coprocessor-0 slice.
//   - CP0 register numbers (rd field of MTC0/MFC0)
//   - Status / Cause field bit positions and the Status writable-bit mask
//   - Exception codes and reset constants
//   - Event type plus a helper resolving simultaneous exception/ERET/MTC0
package cop0_pkg;

    localparam int HW_INT_W = 6;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Status fields
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_UM    = 4;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    // Cause fields
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_TI     = 30;
    localparam int CA_BD     = 31;

    localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF13;
    localparam logic [31:0] STATUS_RESET  = 32'h0000_FF11;
    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    typedef enum logic [4:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_RI  = 5'd10,
        EXC_OV  = 5'd12,
        EXC_FPE = 5'd15
    } exc_code_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_ERET,
        EV_MTC0
    } cop0_event_e;

    // Only one state-changing event is honoured per cycle; the rest are dropped.
    function automatic cop0_event_e pick_event(input logic exc, input logic eret, input logic wr);
        cop0_event_e ev;
        if (exc)       ev = EV_EXC;
        else if (eret) ev = EV_ERET;
        else if (wr)   ev = EV_MTC0;
        else           ev = EV_NONE;
        return ev;
    endfunction

endpackage

// File: rtl/cop0_if.sv
// cop0_if: pipeline <-> CP0 signal bundle.
//   master : pipeline side (drives strobes, PC, interrupt lines; reads data/status)
//   slave  : cop0_unit side
// Signals: iRegWrite/iRegNum/iWriteData/oReadData (MTC0/MFC0),
//          iExcOccurred/iExcCode/iBranchDelay/iInterrupted/iEret (exception control),
//          iPCOriginalWrite/iInstrPC (faulting-PC capture), iHwInt (async interrupts),
//          oPendingInterrupt/oUserMode/oExcLevel/oEPC (status towards the pipeline).
interface cop0_if;
    logic        iRegWrite;
    logic [4:0]  iRegNum;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        iExcOccurred;
    logic [4:0]  iExcCode;
    logic        iBranchDelay;
    logic        iInterrupted;
    logic        iEret;
    logic        iPCOriginalWrite;
    logic [31:0] iInstrPC;
    logic [5:0]  iHwInt;
    logic [7:0]  oPendingInterrupt;
    logic        oUserMode;
    logic        oExcLevel;
    logic [31:0] oEPC;

    modport master (
        output iRegWrite, iRegNum, iWriteData,
        output iExcOccurred, iExcCode, iBranchDelay, iInterrupted, iEret,
        output iPCOriginalWrite, iInstrPC, iHwInt,
        input  oReadData, oPendingInterrupt, oUserMode, oExcLevel, oEPC
    );

    modport slave (
        input  iRegWrite, iRegNum, iWriteData,
        input  iExcOccurred, iExcCode, iBranchDelay, iInterrupted, iEret,
        input  iPCOriginalWrite, iInstrPC, iHwInt,
        output oReadData, oPendingInterrupt, oUserMode, oExcLevel, oEPC
    );
endinterface

// File: rtl/cop0_int_sync.sv
// cop0_int_sync: two-flop synchroniser for the external interrupt lines.
// Ports: iCLK clock; iRST async active-high reset; async_in raw lines;
//        sync_out lines after two flops (two-edge latency).
module cop0_int_sync
    import cop0_pkg::*;
(
    input  logic                iCLK,
    input  logic                iRST,
    input  logic [HW_INT_W-1:0] async_in,
    output logic [HW_INT_W-1:0] sync_out
);
    logic [HW_INT_W-1:0] meta_reg;
    logic [HW_INT_W-1:0] sync_reg;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            meta_reg <= '0;
            sync_reg <= '0;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
        end
    end

    assign sync_out = sync_reg;
endmodule

// File: rtl/cop0_unit.sv
// cop0_unit: MIPS-style coprocessor 0 (Status, Cause, EPC, optional timer).
// Ports: iCLK clock; iRST async active-high reset; bus (cop0_if.slave) carrying
//        MTC0/MFC0 access, exception/ERET control, faulting-PC capture,
//        external interrupt lines and the status outputs.
// Build option: define COP0_TIMER_EN to add Count(9)/Compare(11) and the
//        timer interrupt (Cause.TI, forced onto IP[7]). Without it those
//        registers read 0 and IP[7] follows only the synchronised iHwInt[5].
module cop0_unit
    import cop0_pkg::*;
(
    input  logic  iCLK,
    input  logic  iRST,
    cop0_if.slave bus
);
    // Architectural state
    logic [31:0] status_reg, status_next;
    logic        bd_reg, bd_next;
    logic [4:0]  exc_code_reg, exc_code_next;
    logic [1:0]  sw_ip_reg, sw_ip_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] pc_orig_reg;

    logic [HW_INT_W-1:0] hw_sync;
    logic                timer_ti;
    logic [31:0]         count_rd;
    logic [31:0]         compare_rd;
    logic [7:0]          ip;
    logic [31:0]         cause_rd;
    logic [31:0]         read_data;
    cop0_event_e         ev;

    cop0_int_sync u_int_sync (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .async_in (bus.iHwInt),
        .sync_out (hw_sync)
    );

    assign ev = pick_event(bus.iExcOccurred, bus.iEret, bus.iRegWrite);

    always_comb begin
        status_next   = status_reg;
        bd_next       = bd_reg;
        exc_code_next = exc_code_reg;
        sw_ip_next    = sw_ip_reg;
        epc_next      = epc_reg;
        unique case (ev)
            EV_EXC: begin
                // An interrupted instruction already completed, so resume after it.
                epc_next             = pc_orig_reg + (bus.iInterrupted ? 32'd4 : 32'd0);
                exc_code_next        = bus.iExcCode;
                bd_next              = bus.iBranchDelay;
                status_next[ST_EXL]  = 1'b1;
            end
            EV_ERET: begin
                status_next[ST_EXL]  = 1'b0;
            end
            EV_MTC0: begin
                case (bus.iRegNum)
                    REG_STATUS: status_next = bus.iWriteData & STATUS_WMASK;
                    REG_CAUSE:  sw_ip_next  = bus.iWriteData[CA_IP_LO+1:CA_IP_LO];
                    REG_EPC:    epc_next    = bus.iWriteData;
                    default:    ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            status_reg   <= STATUS_RESET;
            bd_reg       <= 1'b0;
            exc_code_reg <= 5'd0;
            sw_ip_reg    <= 2'b00;
            epc_reg      <= 32'h0;
            pc_orig_reg  <= 32'h0;
        end else begin
            status_reg   <= status_next;
            bd_reg       <= bd_next;
            exc_code_reg <= exc_code_next;
            sw_ip_reg    <= sw_ip_next;
            epc_reg      <= epc_next;
            if (bus.iPCOriginalWrite) begin
                pc_orig_reg <= bus.iInstrPC;
            end
        end
    end

`ifdef COP0_TIMER_EN
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic        ti_reg, ti_next;

    always_comb begin
        count_next   = count_reg + 32'd1;
        compare_next = compare_reg;
        // TI is sticky until software rewrites Compare.
        ti_next      = ti_reg | (count_reg == compare_reg);
        if (ev == EV_MTC0) begin
            if (bus.iRegNum == REG_COUNT) begin
                count_next = bus.iWriteData;
            end
            if (bus.iRegNum == REG_COMPARE) begin
                compare_next = bus.iWriteData;
                ti_next      = 1'b0;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            count_reg   <= 32'h0;
            compare_reg <= COMPARE_RESET;
            ti_reg      <= 1'b0;
        end else begin
            count_reg   <= count_next;
            compare_reg <= compare_next;
            ti_reg      <= ti_next;
        end
    end

    assign timer_ti   = ti_reg;
    assign count_rd   = count_reg;
    assign compare_rd = compare_reg;
`else
    assign timer_ti   = 1'b0;
    assign count_rd   = 32'h0;
    assign compare_rd = 32'h0;
`endif

    // IP[7:2] track the synchronised lines level-sensitively; IP[1:0] are software bits.
    assign ip = {hw_sync[5] | timer_ti, hw_sync[4:0], sw_ip_reg};

    assign cause_rd = {bd_reg, timer_ti, 14'd0, ip, 1'b0, exc_code_reg, 2'b00};

    always_comb begin
        read_data = 32'h0;
        case (bus.iRegNum)
            REG_COUNT:   read_data = count_rd;
            REG_COMPARE: read_data = compare_rd;
            REG_STATUS:  read_data = status_reg;
            REG_CAUSE:   read_data = cause_rd;
            REG_EPC:     read_data = epc_reg;
            default:     read_data = 32'h0;
        endcase
    end

    assign bus.oReadData         = read_data;
    assign bus.oPendingInterrupt = status_reg[ST_IE] ? (ip & status_reg[ST_IM_HI:ST_IM_LO]) : 8'h00;
    assign bus.oUserMode         = status_reg[ST_UM];
    assign bus.oExcLevel         = status_reg[ST_EXL];
    assign bus.oEPC              = epc_reg;
endmodule

// File: tb/tb_cop0_unit.sv
// tb_cop0_unit: table-driven check of cop0_unit plus hand sequences for
// reset-during-exception, interrupt synchroniser latency, exception/ERET
// collision, Cause write masking and (when COP0_TIMER_EN is defined) the timer.
module tb_cop0_unit;
    import cop0_pkg::*;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;

    cop0_if bus ();

    cop0_unit dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        wr;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        exc;
        logic [4:0]  code;
        logic        bd;
        logic        intr;
        logic        eret;
        logic        pcw;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_pend;
        logic        exp_exl;
        logic [31:0] exp_epc;
    } vec_t;

    vec_t vec [0:19];
    int   nv;

    function automatic vec_t mkv(
        input logic wr, input logic [4:0] wnum, input logic [31:0] wdata,
        input logic exc, input logic [4:0] code, input logic bd, input logic intr, input logic eret,
        input logic pcw, input logic [31:0] pc,
        input logic [4:0] rd, input logic [31:0] exp_rd, input logic [7:0] exp_pend,
        input logic exp_exl, input logic [31:0] exp_epc);
        vec_t v;
        v.wr = wr; v.wnum = wnum; v.wdata = wdata;
        v.exc = exc; v.code = code; v.bd = bd; v.intr = intr; v.eret = eret;
        v.pcw = pcw; v.pc = pc;
        v.rd = rd; v.exp_rd = exp_rd; v.exp_pend = exp_pend; v.exp_exl = exp_exl; v.exp_epc = exp_epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clear_strobes();
        bus.iRegWrite        = 1'b0;
        bus.iExcOccurred     = 1'b0;
        bus.iEret            = 1'b0;
        bus.iPCOriginalWrite = 1'b0;
        bus.iInterrupted     = 1'b0;
        bus.iBranchDelay     = 1'b0;
    endtask

    task automatic do_reset();
        clear_strobes();
        bus.iHwInt = 6'h00;
        iRST = 1'b1;
        tick();
        tick();
        iRST = 1'b0;
    endtask

    // Single MTC0, then leave iRegNum selecting `rd` for an MFC0 readback.
    task automatic mtc0(input logic [4:0] num, input logic [31:0] data, input logic [4:0] rd);
        bus.iRegWrite  = 1'b1;
        bus.iRegNum    = num;
        bus.iWriteData = data;
        tick();
        clear_strobes();
        bus.iRegNum = rd;
        #1;
    endtask

    task automatic read_reg(input logic [4:0] num, output logic [31:0] data);
        bus.iRegNum = num;
        #1;
        data = bus.oReadData;
    endtask

    logic [31:0] rd_val;
    logic        found;

    initial begin
        bus.iRegWrite = 1'b0; bus.iRegNum = 5'd0; bus.iWriteData = 32'h0;
        bus.iExcOccurred = 1'b0; bus.iExcCode = 5'd0; bus.iBranchDelay = 1'b0;
        bus.iInterrupted = 1'b0; bus.iEret = 1'b0; bus.iPCOriginalWrite = 1'b0;
        bus.iInstrPC = 32'h0; bus.iHwInt = 6'h00;

        //            wr wnum  wdata         exc code     bd intr eret pcw pc            rd     exp_rd        pend  exl epc
        vec[0]  = mkv(0, 5'd0, 32'h0,        0, 5'd0,     0, 0, 0, 0, 32'h0,         5'd12, 32'h0000_FF11, 8'h00, 0, 32'h0);
        vec[1]  = mkv(0, 5'd0, 32'h0,        0, 5'd0,     0, 0, 0, 0, 32'h0,         5'd13, 32'h0000_0000, 8'h00, 0, 32'h0);
        vec[2]  = mkv(0, 5'd0, 32'h0,        0, 5'd0,     0, 0, 0, 0, 32'h0,         5'd14, 32'h0000_0000, 8'h00, 0, 32'h0);
        vec[3]  = mkv(0, 5'd0, 32'h0,        0, 5'd0,     0, 0, 0, 1, 32'h0040_0010, 5'd14, 32'h0000_0000, 8'h00, 0, 32'h0);
        vec[4]  = mkv(0, 5'd0, 32'h0,        1, EXC_SYS,  1, 0, 0, 0, 32'h0040_0099, 5'd13, 32'h8000_0020, 8'h00, 1, 32'h0040_0010);
        vec[5]  = mkv(0, 5'd0, 32'h0,        0, 5'd0,     0, 0, 0, 0, 32'h0040_0099, 5'd14, 32'h0040_0010, 8'h00, 1, 32'h0040_0010);
        vec[6]  = mkv(1, 5'd12, 32'h0,       1, EXC_RI,   0, 1, 0, 0, 32'h0040_0099, 5'd12, 32'h0000_FF13, 8'h00, 1, 32'h0040_0014);
        vec[7]  = mkv(1, 5'd12, 32'h0,       0, 5'd0,     0, 0, 1, 0, 32'h0040_0099, 5'd12, 32'h0000_FF11, 8'h00, 0, 32'h0040_0014);
        vec[8]  = mkv(1, 5'd12, 32'hFFFF_FFFF, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0099, 5'd12, 32'h0000_FF13, 8'h00, 1, 32'h0040_0014);
        vec[9]  = mkv(1, 5'd12, 32'h0000_FF10, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0099, 5'd12, 32'h0000_FF10, 8'h00, 0, 32'h0040_0014);
        vec[10] = mkv(1, 5'd13, 32'hFFFF_FFFF, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0099, 5'd13, 32'h0000_0328, 8'h00, 0, 32'h0040_0014);
        vec[11] = mkv(1, 5'd12, 32'h0000_0301, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0099, 5'd12, 32'h0000_0301, 8'h03, 0, 32'h0040_0014);
        vec[12] = mkv(1, 5'd7,  32'h1234_5678, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0099, 5'd7,  32'h0000_0000, 8'h03, 0, 32'h0040_0014);
        vec[13] = mkv(1, 5'd13, 32'h0,       0, 5'd0,     0, 0, 0, 0, 32'h0040_0099, 5'd13, 32'h0000_0028, 8'h00, 0, 32'h0040_0014);
        vec[14] = mkv(1, 5'd14, 32'hDEAD_BEEF, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0099, 5'd14, 32'hDEAD_BEEF, 8'h00, 0, 32'hDEAD_BEEF);
        vec[15] = mkv(0, 5'd0, 32'h0,        0, 5'd0,     0, 0, 1, 0, 32'h0040_0099, 5'd14, 32'hDEAD_BEEF, 8'h00, 0, 32'hDEAD_BEEF);
        vec[16] = mkv(0, 5'd0, 32'h0,        0, 5'd0,     0, 0, 0, 1, 32'h0040_0020, 5'd13, 32'h0000_0028, 8'h00, 0, 32'hDEAD_BEEF);
        vec[17] = mkv(0, 5'd0, 32'h0,        1, EXC_INT,  0, 1, 0, 0, 32'h0040_0020, 5'd13, 32'h0000_0000, 8'h00, 1, 32'h0040_0024);
`ifdef COP0_TIMER_EN
        vec[18] = mkv(1, 5'd11, 32'h0000_0005, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0020, 5'd11, 32'h0000_0005, 8'h00, 1, 32'h0040_0024);
        nv = 19;
`else
        vec[18] = mkv(1, 5'd11, 32'h0000_0005, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0020, 5'd11, 32'h0000_0000, 8'h00, 1, 32'h0040_0024);
        vec[19] = mkv(1, 5'd9,  32'h0000_0007, 0, 5'd0,   0, 0, 0, 0, 32'h0040_0020, 5'd9,  32'h0000_0000, 8'h00, 1, 32'h0040_0024);
        nv = 20;
`endif

        do_reset();
        for (int i = 0; i < nv; i++) begin
            bus.iRegWrite        = vec[i].wr;
            bus.iRegNum          = vec[i].wnum;
            bus.iWriteData       = vec[i].wdata;
            bus.iExcOccurred     = vec[i].exc;
            bus.iExcCode         = vec[i].code;
            bus.iBranchDelay     = vec[i].bd;
            bus.iInterrupted     = vec[i].intr;
            bus.iEret            = vec[i].eret;
            bus.iPCOriginalWrite = vec[i].pcw;
            bus.iInstrPC         = vec[i].pc;
            tick();
            clear_strobes();
            bus.iRegNum = vec[i].rd;
            #1;
            check($sformatf("v%0d read r%0d", i, vec[i].rd), bus.oReadData, vec[i].exp_rd);
            check($sformatf("v%0d pending", i), {24'h0, bus.oPendingInterrupt}, {24'h0, vec[i].exp_pend});
            check($sformatf("v%0d exl", i), {31'h0, bus.oExcLevel}, {31'h0, vec[i].exp_exl});
            check($sformatf("v%0d epc", i), bus.oEPC, vec[i].exp_epc);
        end

        // Reset arriving mid-cycle while an exception is being signalled.
        bus.iExcOccurred = 1'b1; bus.iExcCode = EXC_OV; bus.iInterrupted = 1'b1;
        bus.iPCOriginalWrite = 1'b1; bus.iInstrPC = 32'h0000_1000; bus.iRegNum = REG_STATUS;
        #2;
        iRST = 1'b1;
        #1;
        check("rst async epc", bus.oEPC, 32'h0);
        check("rst async exl", {31'h0, bus.oExcLevel}, 32'h0);
        check("rst async status", bus.oReadData, 32'h0000_FF11);
        tick();
        check("rst held epc", bus.oEPC, 32'h0);
        check("rst held um", {31'h0, bus.oUserMode}, 32'h1);
        clear_strobes();
        iRST = 1'b0;
        bus.iInterrupted = 1'b1;
        bus.iExcOccurred = 1'b1;
        tick();
        clear_strobes();
        check("pc_orig cleared by reset", bus.oEPC, 32'h0000_0004);

        // Interrupt synchroniser latency and masking.
        do_reset();
        bus.iHwInt = 6'h01;
        tick();
        check("hwint after 1 edge", {24'h0, bus.oPendingInterrupt}, 32'h0);
        tick();
        check("hwint after 2 edges", {24'h0, bus.oPendingInterrupt}, 32'h04);
        mtc0(REG_STATUS, 32'h0000_FF10, REG_STATUS);
        check("ie cleared pending", {24'h0, bus.oPendingInterrupt}, 32'h0);
        bus.iPCOriginalWrite = 1'b1; bus.iInstrPC = 32'h0040_0020;
        tick();
        clear_strobes();
        bus.iExcOccurred = 1'b1; bus.iInterrupted = 1'b1; bus.iExcCode = EXC_INT;
        tick();
        clear_strobes();
        check("int epc", bus.oEPC, 32'h0040_0024);
        read_reg(REG_CAUSE, rd_val);
        check("int cause", rd_val, 32'h0000_0400);
        check("int exccode", {27'h0, rd_val[6:2]}, 32'h0);
        bus.iHwInt = 6'h20;
        tick();
        tick();
        read_reg(REG_CAUSE, rd_val);
        check("hwint5 ip7", rd_val, 32'h0000_8000);
        bus.iHwInt = 6'h00;

        // Exception colliding with ERET, then ERET alone.
        bus.iEret = 1'b1;
        tick();
        clear_strobes();
        check("eret clears exl", {31'h0, bus.oExcLevel}, 32'h0);
        bus.iPCOriginalWrite = 1'b1; bus.iInstrPC = 32'h0040_0100;
        tick();
        clear_strobes();
        bus.iExcOccurred = 1'b1; bus.iEret = 1'b1; bus.iExcCode = EXC_FPE;
        tick();
        clear_strobes();
        check("exc+eret exl", {31'h0, bus.oExcLevel}, 32'h1);
        check("exc+eret epc", bus.oEPC, 32'h0040_0100);
        bus.iEret = 1'b1;
        tick();
        clear_strobes();
        check("eret exl", {31'h0, bus.oExcLevel}, 32'h0);
        check("eret epc kept", bus.oEPC, 32'h0040_0100);

        // Cause write masking and an unimplemented register.
        do_reset();
        mtc0(REG_CAUSE, 32'hFFFF_FFFF, REG_CAUSE);
        check("cause write mask", bus.oReadData, 32'h0000_0300);
        mtc0(5'd7, 32'hA5A5_A5A5, 5'd7);
        check("reg7 ignored", bus.oReadData, 32'h0);

`ifdef COP0_TIMER_EN
        do_reset();
        mtc0(REG_COMPARE, 32'h0000_0005, REG_CAUSE);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.oReadData[CA_TI]) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("timer ti set", {31'h0, found}, 32'h1);
        check("timer pending7", {31'h0, bus.oPendingInterrupt[7]}, 32'h1);
        read_reg(REG_COUNT, rd_val);
        check("count at ti", rd_val, 32'h0000_0006);
        mtc0(REG_COMPARE, 32'h0000_0064, REG_CAUSE);
        check("compare write clears ti", {31'h0, bus.oReadData[CA_TI]}, 32'h0);
        mtc0(REG_COUNT, 32'hFFFF_FFFF, REG_COUNT);
        check("count load", bus.oReadData, 32'hFFFF_FFFF);
        tick();
        check("count wrap", bus.oReadData, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cop0_unit.md
COP0_UNIT -- requirements
Module: cop0_unit

Interface
REQ-001 SHALL have ports: iCLK in 1 clock; iRST in 1 reset, asynchronous, active-high.
REQ-002 SHALL have: iRegWrite in 1 (MTC0 strobe); iRegNum in 5 (rd field); iWriteData in 32; oReadData out 32 (MFC0 data, combinational on iRegNum).
REQ-003 SHALL have: iExcOccurred in 1; iExcCode in 5; iBranchDelay in 1; iInterrupted in 1; iEret in 1.
REQ-004 SHALL have: iPCOriginalWrite in 1; iInstrPC in 32 (address of executing instruction); iHwInt in 6 (async external interrupt lines).
REQ-005 SHALL have: oPendingInterrupt out 8; oUserMode out 1; oExcLevel out 1; oEPC out 32 (ERET target).

Function
REQ-006 SHALL implement Status(12), Cause(13), EPC(14); with timer enabled also Count(9), Compare(11); other numbers read 0, writes ignored.
REQ-007 Status writable bits SHALL be IM[15:8], UM[4], EXL[1], IE[0]; other bits read 0.
REQ-008 Cause SHALL hold BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] software-writable via MTC0.
REQ-009 SHALL latch iInstrPC into internal rPCOrig on every clock with iPCOriginalWrite=1; hold otherwise.
REQ-010 On iExcOccurred=1 SHALL, same edge: EPC <= rPCOrig (+4 if iInterrupted=1); Cause.ExcCode <= iExcCode; Cause.BD <= iBranchDelay; Status.EXL <= 1.
REQ-011 On iEret=1 SHALL clear Status.EXL at that edge; EPC unchanged.
REQ-012 Priority for same-cycle events SHALL be iExcOccurred > iEret > iRegWrite; lower-priority event discarded.
REQ-013 iHwInt SHALL pass a 2-flop synchroniser, then drive Cause.IP[7:2] level-sensitively (2-cycle latency).
REQ-014 oPendingInterrupt SHALL be Cause.IP & Status.IM when Status.IE=1, else 8'h00; combinational on registered state.
REQ-015 oUserMode SHALL equal Status.UM; oExcLevel SHALL equal Status.EXL; oEPC SHALL equal EPC register.
REQ-016 MTC0 write SHALL take effect at the edge with iRegWrite=1; MFC0 of same register next cycle returns new value.

Reset
REQ-017 On iRST SHALL set Status=32'h0000_FF11, Cause=0, EPC=0, rPCOrig=0, synchroniser flops=0, Count=0, Compare=32'hFFFF_FFFF.
REQ-018 iRST mid-exception SHALL override all pending updates; no partial EPC/Cause write.

Configuration
REQ-019 Macro COP0_TIMER_EN defined: Count increments by 1 every clock, wraps 32'hFFFF_FFFF->0; Count==Compare sets Cause.TI and forces IP[7]=1; MTC0 to Compare clears TI; MTC0 to Count loads it.
REQ-020 COP0_TIMER_EN undefined: no Count/Compare storage, regs 9/11 read 0, TI=0, IP[7] driven only by synchronised iHwInt[5].

Structure
REQ-021 Shared package cop0_pkg SHALL hold register numbers, Status/Cause field bit positions, exception codes (INT=0, SYS=8, RI=10, OV=12, FPE=15), reset constants.
REQ-022 Synchroniser SHALL be sub-module cop0_int_sync (6-bit, 2-flop, async reset).

Verification
REQ-023 Reset, then MFC0 12/13/14 -> 32'h0000_FF11, 0, 0.
REQ-024 iInstrPC=32'h0040_0010 latched, iExcOccurred=1, iExcCode=8, iBranchDelay=1 -> EPC=32'h0040_0010, Cause=32'h8000_0020, oExcLevel=1; rPCOrig frozen while iPCOriginalWrite=0.
REQ-025 iHwInt[0]=1 with Status=32'h0000_FF11 -> oPendingInterrupt=8'h04 after 2 edges; MTC0 Status=32'h0000_FF10 -> 8'h00; iExcOccurred+iInterrupted, rPCOrig=32'h0040_0020 -> EPC=32'h0040_0024, ExcCode=0.
REQ-026 iExcOccurred and iEret same cycle -> EXL=1; then iEret alone -> EXL=0, oEPC unchanged.
REQ-027 COP0_TIMER_EN: MTC0 Compare=5 after reset -> TI=1, oPendingInterrupt[7]=1 from Count==5 edge; MTC0 Compare=100 -> TI=0; Count load 32'hFFFF_FFFF -> wraps to 0.
REQ-028 MTC0 Cause=32'hFFFF_FFFF -> reads 32'h0000_0300 (no hw/timer pending); MTC0 reg 7 -> ignored, reads 0.
